// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus: latched pipeline fields in, decode/debug read ports and retire status out.
// The bench or upstream stage uses master; the register file uses slave.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] MemData;
    logic [DATA_WIDTH-1:0] ALUData;
    logic [ADDR_WIDTH-1:0] WriteReg;
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [ADDR_WIDTH-1:0] ReadReg1;
    logic [ADDR_WIDTH-1:0] ReadReg2;
    logic [ADDR_WIDTH-1:0] DbgReg;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [DATA_WIDTH-1:0] DbgData;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  WriteValid;
    logic [CNT_WIDTH-1:0]  RetireCount;

    modport master (
        output MemData, ALUData, WriteReg, RegWrite, MemtoReg, ReadReg1, ReadReg2, DbgReg,
        input  ReadData1, ReadData2, DbgData, WriteData, WriteValid, RetireCount
    );

    modport slave (
        input  MemData, ALUData, WriteReg, RegWrite, MemtoReg, ReadReg1, ReadReg2, DbgReg,
        output ReadData1, ReadData2, DbgData, WriteData, WriteValid, RetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects the MEM/WB result, commits it to a 32-entry register file,
// and serves two bypassed decode read ports, a committed-state debug port and a retire counter.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1,
    parameter int CNT_WIDTH  = 32
) (
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Flop array rather than block RAM: reads are combinational and reset clears every entry.
    logic [DATA_WIDTH-1:0] regArray [NUM_REGS];
    logic [DATA_WIDTH-1:0] writeData;
    logic                  writeValid;
    logic [CNT_WIDTH-1:0]  retireCountReg;
    logic [ADDR_WIDTH-1:0] readIdx  [2];
    logic [DATA_WIDTH-1:0] readData [2];

    assign writeData  = bus.MemtoReg ? bus.MemData : bus.ALUData;
    // Index 0 is excluded here, so register 0 is never written and never counted.
    assign writeValid = bus.RegWrite && (bus.WriteReg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regArray[i] <= '0;
            end
        end else if (writeValid) begin
            regArray[bus.WriteReg] <= writeData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retireCountReg <= '0;
        end else if (writeValid) begin
            retireCountReg <= retireCountReg + CNT_WIDTH'(1);
        end
    end

    assign readIdx[0] = bus.ReadReg1;
    assign readIdx[1] = bus.ReadReg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_read_port
            always_comb begin
                readData[gi] = regArray[readIdx[gi]];
                if (readIdx[gi] == '0) begin
                    readData[gi] = '0;
                end else if (BYPASS && writeValid && (bus.WriteReg == readIdx[gi])) begin
                    readData[gi] = writeData;
                end
            end
        end
    endgenerate

    assign bus.ReadData1   = readData[0];
    assign bus.ReadData2   = readData[1];
    assign bus.DbgData     = (bus.DbgReg == '0) ? '0 : regArray[bus.DbgReg];
    assign bus.WriteData   = writeData;
    assign bus.WriteValid  = writeValid;
    assign bus.RetireCount = retireCountReg;
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface; consumes the latched MEM/WB fields (MemData, ALUData, WriteReg, RegWrite, MemtoReg).
- Selects the write-back value and commits it to a 32-entry general-purpose register file.
- Provides the decode stage with two read ports (with same-cycle write bypass), plus a debug read port and a retire counter for bench/debug visibility.

Parameters:
DATA_WIDTH, 32, width of register and data words
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH entries)
BYPASS, 1, 1 = read ports return the in-flight write-back value on index match; 0 = read ports return stored contents only
CNT_WIDTH, 32, width of RetireCount

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
MemData  input  DATA_WIDTH  load data from MEM/WB
ALUData  input  DATA_WIDTH  ALU result from MEM/WB
WriteReg  input  ADDR_WIDTH  destination register index
RegWrite  input  1  write enable from MEM/WB
MemtoReg  input  1  1 = write MemData, 0 = write ALUData
ReadReg1  input  ADDR_WIDTH  read port 1 index
ReadReg2  input  ADDR_WIDTH  read port 2 index
DbgReg  input  ADDR_WIDTH  debug read index
ReadData1  output  DATA_WIDTH  read port 1 data
ReadData2  output  DATA_WIDTH  read port 2 data
DbgData  output  DATA_WIDTH  debug read data (no bypass)
WriteData  output  DATA_WIDTH  selected write-back value (forwarding source for EX)
WriteValid  output  1  high when a write commits at the next rising edge
RetireCount  output  CNT_WIDTH  number of committed writes since reset

Behaviour:
- Reset: asynchronous. While reset=1, all registers and RetireCount are 0. reset dominates any write at the same edge.
- WriteData = MemtoReg ? MemData : ALUData. Combinational, and valid even when RegWrite=0.
- WriteValid = RegWrite & (WriteReg != 0). Combinational.
- Commit: on rising clk with reset=0 and WriteValid=1, reg[WriteReg] <= WriteData and RetireCount <= RetireCount + 1.
- RetireCount wraps modulo 2**CNT_WIDTH, with no saturation.
- Register 0:
  - Never written.
  - Always reads 0 on every port, including the bypass path.
  - A write to index 0 does not increment RetireCount.
- Read ports 1/2 are combinational, with zero-cycle latency:
  - ReadRegN == 0 -> 0.
  - Else, if BYPASS=1 and WriteValid and WriteReg == ReadRegN -> WriteData (write-first).
  - Else -> reg[ReadRegN].
- Both read ports may address the same register, with or without bypass, and both return identical data.
- DbgData = reg[DbgReg] (0 for index 0). Never bypassed: it reflects committed state only.
- No internal pipelining: a value written at edge N is visible in stored contents immediately after edge N.
- Reset mid-operation: asserting reset between edges clears contents immediately (asynchronous). The first commit after deassertion happens at the first rising edge with reset=0.
- X on WriteReg while RegWrite=0 must not corrupt state.

Test Plan:
1. Reset: assert reset, drive RegWrite=1, WriteReg=5, ALUData=0xDEADBEEF across 2 edges -> DbgData(5)=0 and RetireCount=0 throughout. Deassert reset, take one edge -> DbgData(5)=0xDEADBEEF, RetireCount=1.
2. Write-back mux: RegWrite=1, WriteReg=3, MemtoReg=1, MemData=0x11112222, ALUData=0x33334444, one edge -> reg3=0x11112222. Repeat with MemtoReg=0 to WriteReg=4 -> reg4=0x33334444, RetireCount=2.
3. Bypass: reg7 holds 0xA5A5A5A5. Drive RegWrite=1, WriteReg=7, ALUData=0x0000BEEF, ReadReg1=ReadReg2=7 before the edge -> ReadData1=ReadData2=0x0000BEEF and DbgData(7)=0xA5A5A5A5. After the edge -> DbgData(7)=0x0000BEEF. With BYPASS=0, the pre-edge reads return 0xA5A5A5A5.
4. Register 0: RegWrite=1, WriteReg=0, ALUData=0xFFFFFFFF, ReadReg1=0 -> ReadData1=0 and WriteValid=0 before and after the edge; RetireCount unchanged.
5. RegWrite=0: WriteReg=9, ALUData=0x12345678, 3 edges -> reg9 unchanged and RetireCount unchanged.
6. Counter wrap (CNT_WIDTH=4): 17 commits to register 1 -> RetireCount sequence ends 15, 0, 1. Then pulse reset asynchronously mid-cycle -> all of DbgData(1..31)=0 and RetireCount=0 immediately, without waiting for a clock edge.
